// File: rtl/updn_count_sched_pkg.sv
// updn_count_sched_pkg: shared state encoding and count-direction constants
package updn_count_sched_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;
endpackage

// File: rtl/updn_count_sched_counter_core.sv
// updn_counter_core: WIDTH-bit up/down counter with enable and synchronous clear
// Ports: CLK clock, RESET sync active-high clear, EN step enable, UD 1=up 0=down, Q count
module updn_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UD,
    output logic [WIDTH-1:0] Q
);
    always_ff @(posedge CLK) begin
        if (RESET) Q <= '0;
        else if (EN) Q <= UD ? Q + 1'b1 : Q - 1'b1;
    end
endmodule

// File: rtl/updn_count_sched.sv
// updn_count_sched: round-robin scheduler driving a shared up/down counter to per-requester targets
// Ports: CLK clock, RESET sync active-high; REQn/TGTn request and target per requester;
//        GNTn ownership, DONEn one-cycle completion pulse, BUSY not idle, UD direction, Q count
module updn_count_sched
    import updn_count_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] TGT0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] TGT1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             BUSY,
    output logic             UD,
    output logic [WIDTH-1:0] Q
);
    state_t           r_state, w_state_n;
    logic             r_owner, w_owner_n;
    logic             r_last, w_last_n;
    logic [WIDTH-1:0] r_tgt, w_tgt_n;
    logic             r_ud, w_ud_n;
    logic             r_gnt0, r_gnt1, r_done0, r_done1, r_busy;
    logic             w_pick, w_req_own, w_en;
    logic [WIDTH-1:0] w_sel_tgt, w_step;

    // on a tie the requester that did not win last time gets the counter
    assign w_pick    = (REQ0 && REQ1) ? ~r_last : REQ1;
    assign w_sel_tgt = w_pick ? TGT1 : TGT0;
    assign w_req_own = r_owner ? REQ1 : REQ0;
    assign w_step    = (r_ud == UP) ? Q + 1'b1 : Q - 1'b1;
    // the counter is frozen on the abort edge so Q keeps the value reached
    assign w_en      = (r_state == RUN) && w_req_own;

    always_comb begin
        w_state_n = r_state;
        w_owner_n = r_owner;
        w_last_n  = r_last;
        w_tgt_n   = r_tgt;
        w_ud_n    = r_ud;
        case (r_state)
            IDLE: if (REQ0 || REQ1) begin
                w_owner_n = w_pick;
                w_last_n  = w_pick;
                w_tgt_n   = w_sel_tgt;
                if (w_sel_tgt == Q) w_state_n = DONE;
                else begin
                    w_ud_n    = (w_sel_tgt > Q) ? UP : DOWN;
                    w_state_n = RUN;
                end
            end
            RUN:     w_state_n = !w_req_own ? IDLE : (w_step == r_tgt) ? DONE : RUN;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tgt   <= '0;
            r_ud    <= DOWN;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_tgt   <= w_tgt_n;
            r_ud    <= w_ud_n;
            r_gnt0  <= (w_state_n != IDLE) && !w_owner_n;
            r_gnt1  <= (w_state_n != IDLE) && w_owner_n;
            r_done0 <= (w_state_n == DONE) && !w_owner_n;
            r_done1 <= (w_state_n == DONE) && w_owner_n;
            r_busy  <= (w_state_n != IDLE);
        end
    end

    updn_counter_core #(.WIDTH(WIDTH)) u_core (
        .CLK  (CLK),
        .RESET(RESET),
        .EN   (w_en),
        .UD   (r_ud),
        .Q    (Q)
    );

    assign GNT0  = r_gnt0;
    assign GNT1  = r_gnt1;
    assign DONE0 = r_done0;
    assign DONE1 = r_done1;
    assign BUSY  = r_busy;
    assign UD    = r_ud;
endmodule

// File: tb/tb_updn_count_sched.sv
// tb_updn_count_sched: directed scoreboard bench for the up/down counter scheduler
module tb_updn_count_sched;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [3:0] TGT0 = '0, TGT1 = '0;
    logic       GNT0, GNT1, DONE0, DONE1, BUSY, UD;
    logic [3:0] Q;

    typedef struct packed {logic who; logic [3:0] q;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    updn_count_sched #(.WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .TGT0(TGT0), .REQ1(REQ1), .TGT1(TGT1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
        .BUSY(BUSY), .UD(UD), .Q(Q)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_done(input logic who, input logic [3:0] q);
        sb.push_back('{who: who, q: q});
    endtask

    always @(negedge CLK) begin
        exp_t e;
        check("gnt_exclusive", int'(GNT0 & GNT1), 0);
        check("done_exclusive", int'(DONE0 & DONE1), 0);
        if (DONE0 || DONE1) begin
            if (sb.size() == 0) check("done_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("done_owner", int'(DONE1), int'(e.who));
                check("done_q", int'(Q), int'(e.q));
                check("done_gnt_held", int'(e.who ? GNT1 : GNT0), 1);
            end
        end
    end

    initial begin
        tick();
        tick();
        RESET = 1'b0;
        check("rst_q", int'(Q), 0);
        check("rst_gnt", int'({GNT1, GNT0}), 0);
        check("rst_done", int'({DONE1, DONE0}), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_ud", int'(UD), 0);

        // count up 0 -> 5 for requester 0
        REQ0 = 1'b1; TGT0 = 4'd5; expect_done(1'b0, 4'd5);
        tick();
        check("up_gnt0", int'(GNT0), 1);
        check("up_busy", int'(BUSY), 1);
        check("up_ud", int'(UD), 1);
        check("up_q0", int'(Q), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("up_q", int'(Q), i);
            check("up_ud_hold", int'(UD), 1);
        end
        REQ0 = 1'b0;
        tick();
        check("up_idle_gnt", int'(GNT0), 0);
        check("up_idle_busy", int'(BUSY), 0);
        check("up_idle_q", int'(Q), 5);

        // count down 5 -> 2 for requester 1
        REQ1 = 1'b1; TGT1 = 4'd2; expect_done(1'b1, 4'd2);
        tick();
        check("dn_gnt1", int'(GNT1), 1);
        check("dn_gnt0", int'(GNT0), 0);
        check("dn_ud", int'(UD), 0);
        for (int i = 4; i >= 2; i--) begin
            tick();
            check("dn_q", int'(Q), i);
            check("dn_gnt0_low", int'(GNT0), 0);
        end
        REQ1 = 1'b0;
        tick();
        check("dn_idle_q", int'(Q), 2);

        // target equals Q: grant and done together, no count
        REQ0 = 1'b1; TGT0 = 4'd2; expect_done(1'b0, 4'd2);
        tick();
        check("eq_gnt0", int'(GNT0), 1);
        check("eq_done0", int'(DONE0), 1);
        REQ0 = 1'b0;
        tick();
        check("eq_gnt_clear", int'(GNT0), 0);
        check("eq_done_clear", int'(DONE0), 0);
        check("eq_q", int'(Q), 2);

        // back to 0, then abort an up-count at Q=7
        REQ0 = 1'b1; TGT0 = 4'd0; expect_done(1'b0, 4'd0);
        tick(); tick(); tick();
        REQ0 = 1'b0;
        tick();
        check("home_q", int'(Q), 0);
        REQ0 = 1'b1; TGT0 = 4'd15;
        tick();
        TGT0 = 4'd3;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("ab_q", int'(Q), i);
        end
        REQ0 = 1'b0;
        tick();
        check("ab_q_hold", int'(Q), 7);
        check("ab_gnt", int'(GNT0), 0);
        check("ab_busy", int'(BUSY), 0);
        tick();
        check("ab_q_hold2", int'(Q), 7);

        // 7 -> 15 without wrap
        REQ1 = 1'b1; TGT1 = 4'd15; expect_done(1'b1, 4'd15);
        tick();
        check("top_ud", int'(UD), 1);
        for (int i = 8; i <= 15; i++) begin
            tick();
            check("top_q", int'(Q), i);
        end
        REQ1 = 1'b0;
        tick();
        check("top_q_hold", int'(Q), 15);

        // reset in the middle of a down-count at Q=9
        REQ0 = 1'b1; TGT0 = 4'd0;
        tick();
        for (int i = 14; i >= 9; i--) tick();
        check("mid_q9", int'(Q), 9);
        RESET = 1'b1; REQ0 = 1'b0; REQ1 = 1'b1; TGT1 = 4'd3;
        tick();
        check("mid_rst_q", int'(Q), 0);
        check("mid_rst_outs", int'({GNT1, GNT0, DONE1, DONE0, BUSY, UD}), 0);
        tick();
        check("mid_rst_gnt1", int'(GNT1), 0);
        RESET = 1'b0; expect_done(1'b1, 4'd3);
        tick();
        check("post_rst_gnt1", int'(GNT1), 1);
        check("post_rst_ud", int'(UD), 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("post_rst_q", int'(Q), i);
        end
        REQ1 = 1'b0;
        tick();

        // round-robin with both requesters pending
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1; TGT0 = 4'd0; TGT1 = 4'd0;
        expect_done(1'b0, 4'd0);
        tick();
        check("rr1_gnt", int'({GNT1, GNT0}), 1);
        tick();
        check("rr1_idle", int'({GNT1, GNT0}), 0);
        expect_done(1'b1, 4'd0);
        tick();
        check("rr2_gnt", int'({GNT1, GNT0}), 2);
        tick();
        check("rr2_idle", int'({GNT1, GNT0}), 0);
        expect_done(1'b0, 4'd0);
        tick();
        check("rr3_gnt", int'({GNT1, GNT0}), 1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        tick();
        check("final_idle_busy", int'(BUSY), 0);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
